pipeline_hazard_controller: RTL and testbench
=============================================

# pipeline_hazard_controller

Sequences the five-stage pipeline around hazards that operand forwarding cannot resolve. The block sits beside the forwarding unit in the ID/EX boundary logic. It issues PC/IF-ID write enables, IF/ID flush and ID/EX bubble insertion for three cases: load-use dependencies, taken branches/jumps resolved in EX, and a multi-cycle multiply/divide unit. It also keeps saturating stall/flush performance counters.

## Interface
Parameters:
- MULT_CYCLES, default 4: busy cycles for a mult/multu.
- DIV_CYCLES, default 32: busy cycles for a div/divu.
- CNT_W, default 16: width of each performance counter.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- ID_Rs, ID_Rt  in  5 each  source registers of the instruction in ID.
- ID_UsesRs, ID_UsesRt  in  1 each  ID instruction actually reads Rs / Rt.
- ID_IsMult, ID_IsDiv  in  1 each  ID instruction is a multiply / divide (mutually exclusive).
- ID_ReadsHiLo  in  1  ID instruction is mfhi/mflo/mthi/mtlo.
- EX_MemRead  in  1  instruction in EX is a load.
- EX_Rw  in  5  destination register of the EX instruction.
- EX_Redirect  in  1  taken branch or jump resolved in EX this cycle.
- PC_Write  out  1  PC update enable.
- IFID_Write  out  1  IF/ID register load enable.
- IFID_Flush  out  1  clear IF/ID to a nop.
- IDEX_Bubble  out  1  load a nop into ID/EX instead of the ID instruction.
- MD_Start  out  1  pulse telling the mult/div unit to latch its operands.
- MD_Busy  out  1  mult/div result not yet valid in HI/LO.
- StallCount, FlushCount  out  CNT_W each  saturating event counters.

## Operation
- Load-use hazard (LU): EX_MemRead and EX_Rw≠0 and ((ID_UsesRs and ID_Rs==EX_Rw) or (ID_UsesRt and ID_Rt==EX_Rw)).
- HI/LO hazard (HL): MD_Busy and (ID_ReadsHiLo or ID_IsMult or ID_IsDiv).
- Stall = (LU or HL) and not EX_Redirect.
- Stall response: PC_Write=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=0.
- EX_Redirect response, which overrides stall: PC_Write=1, IFID_Write=1, IFID_Flush=1, IDEX_Bubble=1. The ID instruction is squashed, any pending stall is discarded, and an ID mult/div does not start.
- Otherwise (advance): PC_Write=1, IFID_Write=1, IFID_Flush=0, IDEX_Bubble=0.
- MD_Start = (ID_IsMult or ID_IsDiv) and advance.
- Mult/div FSM states are IDLE and BUSY; a down-counter has width ceil(log2(DIV_CYCLES+1)).
  - IDLE→BUSY on MD_Start. Counter loads MULT_CYCLES or DIV_CYCLES.
  - In BUSY the counter decrements each cycle. BUSY→IDLE on the cycle the counter reaches 1, with MD_Busy low the following cycle.
  - MD_Busy = (state==BUSY).
  - MD_Start cannot occur in BUSY, because HL stalls any new mult/div.
- EX_Redirect does not abort BUSY. An already-issued mult/div always completes.
- Counters:
  - StallCount increments on each stall cycle.
  - FlushCount increments on each EX_Redirect cycle.
  - Both saturate at 2^CNT_W−1 and never wrap.

## Timing
- Stall, flush, advance and MD_Start outputs are combinational from the current-cycle inputs and state. There are no registered hazard outputs.
- LU stalls exactly one cycle. On the next cycle the load is in MEM and the forwarding unit supplies the data.
- Mult issued (MD_Start) in cycle t: MD_Busy=1 for cycles t+1 … t+MULT_CYCLES, and 0 at t+MULT_CYCLES+1. A dependent mflo in ID stalls through t+MULT_CYCLES and advances at t+MULT_CYCLES+1. Divide is the same with DIV_CYCLES.
- Simultaneous LU and HL: one stall cycle is counted once. The stall persists while either holds.
- While Reset=1, regardless of other inputs:
  - PC_Write=0, IFID_Write=0, IFID_Flush=1, IDEX_Bubble=1, MD_Start=0.
  - At the clock edge: FSM→IDLE, counter→0, StallCount=FlushCount=0, so MD_Busy=0 from the next cycle.
  - Reset during BUSY abandons the operation.
- ID_Rs/ID_Rt==0 never produces LU.

## Structure
- A shared package (mips_pipe_pkg) holds the FSM state encoding (IDLE=0, BUSY=1) and the MULT_CYCLES/DIV_CYCLES defaults.
- Sub-module md_busy_timer holds the IDLE/BUSY FSM and down-counter. Its inputs are start and is_div; its output is busy.
- The top level contains the hazard equations, output muxing and the saturating counters.

## Test plan
- Load-use: lw $8 in EX, add using $8 as Rt in ID → one cycle with PC_Write=0, IDEX_Bubble=1. Next cycle advances. StallCount=1.
- Zero register: lw $0 in EX, ID reads $0 → no stall, all outputs in advance pattern.
- Mult then mflo: MD_Start at t, mflo in ID at t+1 → stalled t+1…t+4, advances t+5. MD_Busy falls at t+5. StallCount=4.
- Redirect plus LU in the same cycle → IFID_Flush=1, IDEX_Bubble=1, PC_Write=1. StallCount unchanged, FlushCount+1. A mult in ID gives MD_Start=0.
- Reset mid-divide: Reset high at t+10 of a 32-cycle div → MD_Busy=0 at t+11. Counters read 0. A new div after reset runs the full 32 cycles.
- Saturation with CNT_W=4: 20 consecutive redirect cycles → FlushCount holds at 15.

Source files
------------

// File: rtl/pipeline_hazard_controller_pkg.sv
// ---------------------------------------------------------------------------
// mips_pipe_pkg
// Shared definitions for the pipeline hazard controller slice:
//   - md_state_e   : encoding of the mult/div busy-timer FSM (IDLE=0, BUSY=1)
//   - DEF_*_CYCLES : default latencies of the multi-cycle mult/div unit
//   - pipe_ctl_t   : bundle of the four pipeline-register control strobes,
//                    plus the constant patterns for each pipeline response
//   - regMatch     : "ID source really depends on EX destination" helper
// ---------------------------------------------------------------------------
package mips_pipe_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam int DEF_MULT_CYCLES = 4;
  localparam int DEF_DIV_CYCLES  = 32;

  // Control strobes driven to PC, IF/ID and ID/EX, in one bundle so the
  // response selection below is a single mux over whole patterns.
  typedef struct packed {
    logic pcWrite;
    logic ifidWrite;
    logic ifidFlush;
    logic idexBubble;
  } pipe_ctl_t;

  // Normal flow: everything moves forward.
  localparam pipe_ctl_t CTL_ADVANCE  = '{pcWrite: 1'b1, ifidWrite: 1'b1,
                                         ifidFlush: 1'b0, idexBubble: 1'b0};
  // Hold PC and IF/ID, send a nop into EX.
  localparam pipe_ctl_t CTL_STALL    = '{pcWrite: 1'b0, ifidWrite: 1'b0,
                                         ifidFlush: 1'b0, idexBubble: 1'b1};
  // Fetch from the new target, squash both the fetched and the ID instruction.
  localparam pipe_ctl_t CTL_REDIRECT = '{pcWrite: 1'b1, ifidWrite: 1'b1,
                                         ifidFlush: 1'b1, idexBubble: 1'b1};
  // Frozen PC with nops everywhere while the core is held in reset.
  localparam pipe_ctl_t CTL_RESET    = '{pcWrite: 1'b0, ifidWrite: 1'b0,
                                         ifidFlush: 1'b1, idexBubble: 1'b1};

  // $0 is hard-wired, so a "write" to it can never create a dependency.
  function automatic logic regMatch(input logic       uses,
                                    input logic [4:0] src,
                                    input logic [4:0] dst);
    return uses && (src == dst) && (dst != 5'd0);
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller_if
// Bundles the ID/EX hazard inputs and the pipeline control / status outputs
// of the hazard controller.
//   master : pipeline side, drives the ID/EX decode info, observes controls
//   slave  : the hazard controller itself
// Signals:
//   ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt      ID source operands
//   ID_IsMult, ID_IsDiv, ID_ReadsHiLo       ID HI/LO related decode
//   EX_MemRead, EX_Rw, EX_Redirect          EX load / destination / redirect
//   PC_Write, IFID_Write, IFID_Flush,
//   IDEX_Bubble                             pipeline register controls
//   MD_Start, MD_Busy                       mult/div unit handshake
//   StallCount, FlushCount                  saturating event counters
// ---------------------------------------------------------------------------
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 16
);

  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             ID_UsesRs;
  logic             ID_UsesRt;
  logic             ID_IsMult;
  logic             ID_IsDiv;
  logic             ID_ReadsHiLo;
  logic             EX_MemRead;
  logic [4:0]       EX_Rw;
  logic             EX_Redirect;

  logic             PC_Write;
  logic             IFID_Write;
  logic             IFID_Flush;
  logic             IDEX_Bubble;
  logic             MD_Start;
  logic             MD_Busy;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_IsMult, ID_IsDiv,
           ID_ReadsHiLo, EX_MemRead, EX_Rw, EX_Redirect,
    input  PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, MD_Start, MD_Busy,
           StallCount, FlushCount
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_IsMult, ID_IsDiv,
           ID_ReadsHiLo, EX_MemRead, EX_Rw, EX_Redirect,
    output PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, MD_Start, MD_Busy,
           StallCount, FlushCount
  );

endinterface

// File: rtl/pipeline_hazard_controller_md_busy_timer.sv
// ---------------------------------------------------------------------------
// md_busy_timer
// Tracks how long the multi-cycle mult/div unit keeps HI/LO invalid.
// A start pulse in IDLE loads a down-counter with the operation latency;
// busy stays high until the cycle in which the counter reads 1, so busy is
// asserted for exactly MULT_CYCLES / DIV_CYCLES cycles after the start cycle.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset, abandons any operation
//   start  in   latch a new mult/div (only honoured in IDLE)
//   is_div in   selects the divide latency for the starting operation
//   busy   out  HI/LO result not yet valid
// ---------------------------------------------------------------------------
module md_busy_timer
  import mips_pipe_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int            CW        = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] LAST      = CW'(1);

  md_state_e     state_q;
  logic [CW-1:0] count_q;

  // The hazard logic stalls any new mult/div while BUSY, so start is only
  // looked at in IDLE. The counter reaching 1 marks the final busy cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= BUSY;
            count_q <= is_div ? DIV_LOAD : MULT_LOAD;
          end
        end
        BUSY: begin
          count_q <= count_q - LAST;
          if (count_q == LAST) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

  assign busy = (state_q == BUSY);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller
// Sequences the five-stage pipeline around hazards forwarding cannot cover:
//   - load-use : ID reads the register an EX load is about to write
//   - HI/LO    : ID touches HI/LO (or starts another mult/div) while the
//                mult/div unit is still busy
//   - redirect : taken branch/jump resolved in EX, which wins over a stall
// All pipeline controls are combinational from this cycle's inputs and the
// busy-timer state. Stall and flush cycles are counted in saturating
// counters.
// Ports:
//   CLK    in   rising-edge clock
//   Reset  in   synchronous active-high reset
//   bus    slave side of pipeline_hazard_controller_if (hazard inputs,
//          pipeline controls, mult/div handshake, event counters)
// ---------------------------------------------------------------------------
module pipeline_hazard_controller
  import mips_pipe_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = 16
) (
  input logic                          CLK,
  input logic                          Reset,
  pipeline_hazard_controller_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             loadUse;
  logic             hiLoHazard;
  logic             stall;
  logic             mdBusy;
  logic             mdStart;
  logic             isMulDiv;
  pipe_ctl_t        ctl;
  logic [CNT_W-1:0] stallCount_q;
  logic [CNT_W-1:0] stallCount_d;
  logic [CNT_W-1:0] flushCount_q;
  logic [CNT_W-1:0] flushCount_d;

  // Hazard detection. Load-use is a one-cycle hazard: next cycle the load
  // sits in MEM and forwarding takes over. A mult/div in ID also waits for
  // a busy unit, since it would overwrite HI/LO under the running operation.
  assign isMulDiv   = bus.ID_IsMult || bus.ID_IsDiv;
  assign loadUse    = bus.EX_MemRead &&
                      (regMatch(bus.ID_UsesRs, bus.ID_Rs, bus.EX_Rw) ||
                       regMatch(bus.ID_UsesRt, bus.ID_Rt, bus.EX_Rw));
  assign hiLoHazard = mdBusy && (bus.ID_ReadsHiLo || isMulDiv);
  assign stall      = !Reset && (loadUse || hiLoHazard) && !bus.EX_Redirect;

  // Response priority: reset, then redirect (squashes the stalled
  // instruction, so stalling it would be pointless), then stall. A mult/div
  // only starts when its instruction really leaves ID.
  always_comb begin
    ctl     = CTL_ADVANCE;
    mdStart = 1'b0;
    if (Reset) begin
      ctl = CTL_RESET;
    end else if (bus.EX_Redirect) begin
      ctl = CTL_REDIRECT;
    end else if (stall) begin
      ctl = CTL_STALL;
    end else begin
      mdStart = isMulDiv;
    end
  end

  // Event counters stick at all-ones rather than wrapping, so a long run
  // never reads back as a small count.
  always_comb begin
    stallCount_d = stallCount_q;
    flushCount_d = flushCount_q;
    if (stall && (stallCount_q != CNT_MAX)) begin
      stallCount_d = stallCount_q + CNT_ONE;
    end
    if (bus.EX_Redirect && (flushCount_q != CNT_MAX)) begin
      flushCount_d = flushCount_q + CNT_ONE;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      stallCount_q <= '0;
      flushCount_q <= '0;
    end else begin
      stallCount_q <= stallCount_d;
      flushCount_q <= flushCount_d;
    end
  end

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_mdTimer (
    .clk    (CLK),
    .reset  (Reset),
    .start  (mdStart),
    .is_div (bus.ID_IsDiv),
    .busy   (mdBusy)
  );

  assign bus.PC_Write    = ctl.pcWrite;
  assign bus.IFID_Write  = ctl.ifidWrite;
  assign bus.IFID_Flush  = ctl.ifidFlush;
  assign bus.IDEX_Bubble = ctl.idexBubble;
  assign bus.MD_Start    = mdStart;
  assign bus.MD_Busy     = mdBusy;
  assign bus.StallCount  = stallCount_q;
  assign bus.FlushCount  = flushCount_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_controller
// Self-checking bench for pipeline_hazard_controller (CNT_W=4 so counter
// saturation is reachable quickly). Every cycle is compared against a
// behavioural model that tracks "cycles of mult/div still outstanding" and
// plain integer counters; table vectors and hand-written sequences add
// fixed expected values on top.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

  localparam int MULT_N  = 4;
  localparam int DIV_N   = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRs;
    logic       usesRt;
    logic       isMult;
    logic       isDiv;
    logic       readsHiLo;
    logic       memRead;
    logic [4:0] exRw;
    logic       redirect;
  } stim_t;

  typedef struct {
    logic pcWrite;
    logic ifidWrite;
    logic ifidFlush;
    logic idexBubble;
    logic mdStart;
    logic mdBusy;
    int   stallCount;
    int   flushCount;
  } resp_t;

  // ctl = {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, MD_Start}
  typedef struct {
    stim_t      s;
    logic [4:0] ctl;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  int compared   = 0;
  int mismatched = 0;

  int busyLeft = 0;
  int stallCnt = 0;
  int flushCnt = 0;

  resp_t obs;

  always #5 clk = ~clk;

  pipeline_hazard_controller_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_controller #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N),
    .CNT_W       (CNT_W)
  ) dut (
    .CLK   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  function automatic stim_t mkStim(input logic rst, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic usesRs,
                                   input logic usesRt, input logic isMult,
                                   input logic isDiv, input logic readsHiLo,
                                   input logic memRead, input logic [4:0] exRw,
                                   input logic redirect);
    stim_t s;
    s.rst = rst; s.rs = rs; s.rt = rt; s.usesRs = usesRs; s.usesRt = usesRt;
    s.isMult = isMult; s.isDiv = isDiv; s.readsHiLo = readsHiLo;
    s.memRead = memRead; s.exRw = exRw; s.redirect = redirect;
    return s;
  endfunction

  // Reference behaviour: what the pipeline should see this cycle.
  function automatic resp_t modelPredict(input stim_t s);
    resp_t r;
    logic  lu;
    logic  hl;
    r.mdBusy     = (busyLeft > 0);
    r.stallCount = stallCnt;
    r.flushCount = flushCnt;
    r.mdStart    = 1'b0;
    lu = s.memRead && (s.exRw != 0) &&
         ((s.usesRs && s.rs == s.exRw) || (s.usesRt && s.rt == s.exRw));
    hl = (busyLeft > 0) && (s.readsHiLo || s.isMult || s.isDiv);
    if (s.rst) begin
      {r.pcWrite, r.ifidWrite, r.ifidFlush, r.idexBubble} = 4'b0011;
    end else if (s.redirect) begin
      {r.pcWrite, r.ifidWrite, r.ifidFlush, r.idexBubble} = 4'b1111;
    end else if (lu || hl) begin
      {r.pcWrite, r.ifidWrite, r.ifidFlush, r.idexBubble} = 4'b0001;
    end else begin
      {r.pcWrite, r.ifidWrite, r.ifidFlush, r.idexBubble} = 4'b1100;
      r.mdStart = s.isMult || s.isDiv;
    end
    return r;
  endfunction

  task automatic modelAdvance(input stim_t s, input resp_t r);
    if (s.rst) begin
      busyLeft = 0;
      stallCnt = 0;
      flushCnt = 0;
    end else begin
      if (busyLeft > 0) busyLeft--;
      if (r.mdStart) busyLeft = s.isDiv ? DIV_N : MULT_N;
      if (!r.pcWrite && stallCnt < CNT_MAX) stallCnt++;
      if (s.redirect && flushCnt < CNT_MAX) flushCnt++;
    end
  endtask

  task automatic checkField(input string name, input int act, input int req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    reset            = s.rst;
    bus.ID_Rs        = s.rs;
    bus.ID_Rt        = s.rt;
    bus.ID_UsesRs    = s.usesRs;
    bus.ID_UsesRt    = s.usesRt;
    bus.ID_IsMult    = s.isMult;
    bus.ID_IsDiv     = s.isDiv;
    bus.ID_ReadsHiLo = s.readsHiLo;
    bus.EX_MemRead   = s.memRead;
    bus.EX_Rw        = s.exRw;
    bus.EX_Redirect  = s.redirect;
  endtask

  task automatic checkOutput(input string tag, input resp_t a, input resp_t e);
    checkField({tag, ".PC_Write"},    int'(a.pcWrite),    int'(e.pcWrite));
    checkField({tag, ".IFID_Write"},  int'(a.ifidWrite),  int'(e.ifidWrite));
    checkField({tag, ".IFID_Flush"},  int'(a.ifidFlush),  int'(e.ifidFlush));
    checkField({tag, ".IDEX_Bubble"}, int'(a.idexBubble), int'(e.idexBubble));
    checkField({tag, ".MD_Start"},    int'(a.mdStart),    int'(e.mdStart));
    checkField({tag, ".MD_Busy"},     int'(a.mdBusy),     int'(e.mdBusy));
    checkField({tag, ".StallCount"},  a.stallCount,       e.stallCount);
    checkField({tag, ".FlushCount"},  a.flushCount,       e.flushCount);
  endtask

  // One clock: drive just after the edge, sample and compare at the falling
  // edge, then let the model follow the rising edge.
  task automatic runCycle(input stim_t s, input string tag);
    resp_t e;
    applyStimulus(s);
    @(negedge clk);
    obs.pcWrite    = bus.PC_Write;
    obs.ifidWrite  = bus.IFID_Write;
    obs.ifidFlush  = bus.IFID_Flush;
    obs.idexBubble = bus.IDEX_Bubble;
    obs.mdStart    = bus.MD_Start;
    obs.mdBusy     = bus.MD_Busy;
    obs.stallCount = int'(bus.StallCount);
    obs.flushCount = int'(bus.FlushCount);
    e = modelPredict(s);
    checkOutput(tag, obs, e);
    @(posedge clk);
    modelAdvance(s, e);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t idle;
    stim_t rstS;
    stim_t luS;
    stim_t multS;
    stim_t divS;
    stim_t mfloS;
    stim_t redirS;
    stim_t s;
    vec_t  vecs[14];
    int    busyCycles;
    int    r;

    idle   = mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rstS   = mkStim(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    luS    = mkStim(0, 3, 8, 1, 1, 0, 0, 0, 1, 8, 0);
    multS  = mkStim(0, 4, 5, 1, 1, 1, 0, 0, 0, 0, 0);
    divS   = mkStim(0, 6, 7, 1, 1, 0, 1, 0, 0, 0, 0);
    mfloS  = mkStim(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    redirS = mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    vecs[0]  = '{mkStim(0, 3, 8, 1, 1, 0, 0, 0, 1, 8, 0), 5'b00010};
    vecs[1]  = '{mkStim(0, 9, 4, 1, 1, 0, 0, 0, 1, 9, 0), 5'b00010};
    vecs[2]  = '{mkStim(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0), 5'b11000};
    vecs[3]  = '{mkStim(0, 5, 8, 1, 0, 0, 0, 0, 1, 8, 0), 5'b11000};
    vecs[4]  = '{mkStim(0, 8, 8, 1, 1, 0, 0, 0, 0, 8, 0), 5'b11000};
    vecs[5]  = '{mkStim(0, 8, 2, 1, 1, 0, 0, 0, 1, 8, 1), 5'b11110};
    vecs[6]  = '{mkStim(0, 4, 5, 1, 1, 1, 0, 0, 0, 0, 0), 5'b11001};
    vecs[7]  = '{mkStim(0, 4, 5, 1, 1, 1, 0, 0, 0, 0, 1), 5'b11110};
    vecs[8]  = '{mkStim(0, 6, 7, 1, 1, 0, 1, 0, 1, 7, 0), 5'b00010};
    vecs[9]  = '{mkStim(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 5'b11000};
    vecs[10] = '{mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 5'b11110};
    vecs[11] = '{mkStim(0, 3, 4, 1, 1, 0, 0, 0, 1, 5, 0), 5'b11000};
    vecs[12] = '{mkStim(0, 2, 3, 1, 1, 0, 1, 0, 1, 9, 0), 5'b11001};
    vecs[13] = '{mkStim(0, 8, 1, 1, 1, 1, 0, 0, 1, 8, 1), 5'b11110};

    // Bring the design out of its unknown power-up state unchecked.
    applyStimulus(rstS);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset state");
    runCycle(rstS, "reset");
    checkField("reset.ctl", int'({obs.pcWrite, obs.ifidWrite, obs.ifidFlush,
                                  obs.idexBubble, obs.mdStart}), 5'b00110);
    runCycle(idle, "afterReset");
    checkField("afterReset.MD_Busy", int'(obs.mdBusy), 0);
    checkField("afterReset.StallCount", obs.stallCount, 0);

    $display("[TB] table vectors");
    for (int i = 0; i < 14; i++) begin
      runCycle(vecs[i].s, $sformatf("vec%0d", i));
      checkField($sformatf("vec%0d.ctl", i),
                 int'({obs.pcWrite, obs.ifidWrite, obs.ifidFlush,
                       obs.idexBubble, obs.mdStart}), int'(vecs[i].ctl));
      runCycle(rstS, "vecReset");
    end

    $display("[TB] load-use single stall");
    runCycle(luS, "luStall");
    runCycle(idle, "luNext");
    checkField("luNext.PC_Write", int'(obs.pcWrite), 1);
    checkField("luNext.StallCount", obs.stallCount, 1);

    $display("[TB] mult then mflo");
    runCycle(rstS, "mulReset");
    runCycle(multS, "mulIssue");
    checkField("mulIssue.MD_Start", int'(obs.mdStart), 1);
    for (int k = 1; k <= MULT_N; k++) begin
      runCycle(mfloS, $sformatf("mflo_t%0d", k));
      checkField($sformatf("mflo_t%0d.PC_Write", k), int'(obs.pcWrite), 0);
      checkField($sformatf("mflo_t%0d.MD_Busy", k), int'(obs.mdBusy), 1);
    end
    runCycle(mfloS, "mfloGo");
    checkField("mfloGo.PC_Write", int'(obs.pcWrite), 1);
    checkField("mfloGo.MD_Busy", int'(obs.mdBusy), 0);
    checkField("mfloGo.StallCount", obs.stallCount, 4);

    $display("[TB] redirect with load-use and mult");
    runCycle(rstS, "redReset");
    s = mkStim(0, 8, 1, 1, 1, 1, 0, 0, 1, 8, 1);
    runCycle(s, "redLuMul");
    checkField("redLuMul.ctl", int'({obs.pcWrite, obs.ifidWrite, obs.ifidFlush,
                                     obs.idexBubble, obs.mdStart}), 5'b11110);
    runCycle(idle, "redNext");
    checkField("redNext.StallCount", obs.stallCount, 0);
    checkField("redNext.FlushCount", obs.flushCount, 1);
    checkField("redNext.MD_Busy", int'(obs.mdBusy), 0);

    $display("[TB] reset mid-divide");
    runCycle(rstS, "divReset");
    runCycle(divS, "divIssue");
    checkField("divIssue.MD_Start", int'(obs.mdStart), 1);
    runCycle(redirS, "div_t1");
    for (int k = 2; k <= 9; k++) runCycle(idle, $sformatf("div_t%0d", k));
    runCycle(rstS, "div_t10");
    checkField("div_t10.MD_Busy", int'(obs.mdBusy), 1);
    runCycle(idle, "div_t11");
    checkField("div_t11.MD_Busy", int'(obs.mdBusy), 0);
    checkField("div_t11.FlushCount", obs.flushCount, 0);
    checkField("div_t11.StallCount", obs.stallCount, 0);
    runCycle(divS, "div2Issue");
    busyCycles = 0;
    for (int k = 0; k < 100; k++) begin
      runCycle(idle, "div2Run");
      if (!obs.mdBusy) break;
      busyCycles++;
    end
    checkField("div2.busyLength", busyCycles, DIV_N);

    $display("[TB] flush counter saturation");
    runCycle(rstS, "satReset");
    for (int k = 0; k < 20; k++) runCycle(redirS, "satRedirect");
    runCycle(idle, "satEnd");
    checkField("satEnd.FlushCount", obs.flushCount, CNT_MAX);

    $display("[TB] randomized run");
    runCycle(rstS, "rndReset");
    for (int k = 0; k < 400; k++) begin
      s.rst       = ($urandom_range(0, 59) == 0);
      s.rs        = 5'($urandom_range(0, 3));
      s.rt        = 5'($urandom_range(0, 3));
      s.usesRs    = 1'($urandom_range(0, 1));
      s.usesRt    = 1'($urandom_range(0, 1));
      r           = $urandom_range(0, 9);
      s.isMult    = (r == 0);
      s.isDiv     = (r == 1) && ($urandom_range(0, 3) == 0);
      s.readsHiLo = ($urandom_range(0, 4) == 0);
      s.memRead   = 1'($urandom_range(0, 1));
      s.exRw      = 5'($urandom_range(0, 3));
      s.redirect  = ($urandom_range(0, 6) == 0);
      runCycle(s, $sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
